csr_trap_ctrl: RTL and testbench

Parametrised machine-mode CSR file and trap controller for the RV32 core, one generation on from the fixed-width CSR block. It holds the M-mode CSRs, an internal 64-bit machine timer with prescaler, and a configurable bank of platform interrupt lines with fixed-priority arbitration. Traps, interrupts and `mret` redirects are issued to fetch through a valid/ready handshake. It sits beside the execute stage: execute reports exceptions and `mret`, fetch consumes redirects.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_mtimer.sv | 37 +++
 rtl/csr_trap_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, interrupt cause codes, mstatus fields and trap FSM state
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMPH = 12'h7C1;
  localparam logic [11:0] CSR_MTIME     = 12'hC01;
  localparam logic [11:0] CSR_MTIMEH    = 12'hC81;

  localparam int IRQ_MSI       = 3;
  localparam int IRQ_MTI       = 7;
  localparam int IRQ_MEI       = 11;
  localparam int IRQ_PLAT_BASE = 16;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // MXL=1 (32-bit), extension I only
  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  typedef enum logic {ST_IDLE, ST_REDIR} trap_state_e;

  function automatic logic csr_writable(input logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MIP, CSR_MTIMECMP, CSR_MTIMECMPH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_mtimer.sv
// rtl/csr_mtimer.sv - prescaled 64-bit mtime, mtimecmp and registered MTIP compare
module csr_mtimer #(
  parameter int TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmp_we_lo,
  input  logic        cmp_we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TIMER_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      mtip     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) mtime <= mtime + 64'd1;
      if (cmp_we_lo) mtimecmp[31:0]  <= wdata;
      if (cmp_we_hi) mtimecmp[63:32] <= wdata;
      mtip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - M-mode CSR file and trap/redirect controller; CSR_VECTORED_EN enables vectored mtvec
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter int               NUM_PLAT_IRQ = 4,
  parameter int               TIMER_DIV    = 1,
  parameter logic [XLEN-1:0]  RESET_MTVEC  = 32'h0000_0000,
  parameter int               HART_ID      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             csr_raddr,
  output logic [XLEN-1:0]         csr_rdata,
  output logic                    csr_illegal,
  input  logic                    csr_we,
  input  logic [11:0]             csr_waddr,
  input  logic [XLEN-1:0]         csr_wdata,
  input  logic                    exc_valid,
  input  logic [XLEN-1:0]         exc_cause,
  input  logic [XLEN-1:0]         exc_tval,
  input  logic [XLEN-1:0]         exc_pc,
  input  logic [XLEN-1:0]         int_pc,
  input  logic                    mret_valid,
  input  logic                    int_block,
  input  logic                    meip,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq,
  output logic                    redir_valid,
  output logic [XLEN-1:0]         redir_pc,
  input  logic                    redir_ready
);

  localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'd1 << NUM_PLAT_IRQ) - 32'd1) << IRQ_PLAT_BASE);

  trap_state_e             state;
  logic                    st_mie, st_mpie, msip, meip_q;
  logic [NUM_PLAT_IRQ-1:0] plat_q;
  logic [31:0]             mie_r, mscratch, mcause_r, mtval_r;
  logic [31:2]             mepc_r, mtvec_base;
  logic                    mtvec_mode;
  logic [63:0]             mtime, mtimecmp;
  logic                    mtip;

  logic [31:0] mstatus_rd, mip_rd, mtvec_rd, pending, base, int_target;
  logic [4:0]  int_code;
  logic        int_hit, rd_impl, exc_take, int_take, mret_take, wr_ok;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign base       = {mtvec_base, 2'b00};

`ifdef CSR_VECTORED_EN
  assign mtvec_rd   = {mtvec_base, 1'b0, mtvec_mode};
  assign int_target = mtvec_mode ? base + {25'b0, int_code, 2'b00} : base;
`else
  assign mtvec_rd   = base;
  assign int_target = base;
`endif

  always_comb begin
    mip_rd = '0;
    mip_rd[IRQ_MSI] = msip;
    mip_rd[IRQ_MTI] = mtip;
    mip_rd[IRQ_MEI] = meip_q;
    mip_rd[IRQ_PLAT_BASE +: NUM_PLAT_IRQ] = plat_q;
  end

  assign pending = mip_rd & mie_r & {32{st_mie}};

  // Later assignments win, so the highest-priority source is written last
  always_comb begin
    int_hit  = 1'b0;
    int_code = 5'd0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (pending[IRQ_PLAT_BASE + i]) begin
        int_hit  = 1'b1;
        int_code = 5'(IRQ_PLAT_BASE + i);
      end
    end
    if (pending[IRQ_MTI]) begin int_hit = 1'b1; int_code = 5'(IRQ_MTI); end
    if (pending[IRQ_MSI]) begin int_hit = 1'b1; int_code = 5'(IRQ_MSI); end
    if (pending[IRQ_MEI]) begin int_hit = 1'b1; int_code = 5'(IRQ_MEI); end
  end

  assign exc_take  = (state == ST_IDLE) && exc_valid;
  assign int_take  = (state == ST_IDLE) && int_hit && !int_block;
  assign mret_take = (state == ST_IDLE) && mret_valid;
  assign wr_ok     = csr_we && csr_writable(csr_waddr) && !(exc_take || int_take || mret_take);

  always_comb begin
    csr_rdata = '0;
    rd_impl   = 1'b1;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MISA:      csr_rdata = MISA_VAL;
      CSR_MIE:       csr_rdata = mie_r;
      CSR_MTVEC:     csr_rdata = mtvec_rd;
      CSR_MSCRATCH:  csr_rdata = mscratch;
      CSR_MEPC:      csr_rdata = {mepc_r, 2'b00};
      CSR_MCAUSE:    csr_rdata = mcause_r;
      CSR_MTVAL:     csr_rdata = mtval_r;
      CSR_MIP:       csr_rdata = mip_rd;
      CSR_MHARTID:   csr_rdata = 32'(HART_ID);
      CSR_MTIMECMP:  csr_rdata = mtimecmp[31:0];
      CSR_MTIMECMPH: csr_rdata = mtimecmp[63:32];
      CSR_MTIME:     csr_rdata = mtime[31:0];
      CSR_MTIMEH:    csr_rdata = mtime[63:32];
      default:       rd_impl   = 1'b0;
    endcase
  end

  assign csr_illegal = !rd_impl || (csr_we && !csr_writable(csr_waddr));

  csr_mtimer #(.TIMER_DIV(TIMER_DIV)) u_mtimer (
    .clk       (clk),
    .rst       (rst),
    .cmp_we_lo (wr_ok && csr_waddr == CSR_MTIMECMP),
    .cmp_we_hi (wr_ok && csr_waddr == CSR_MTIMECMPH),
    .wdata     (csr_wdata),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .mtip      (mtip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      msip        <= 1'b0;
      meip_q      <= 1'b0;
      plat_q      <= '0;
      mie_r       <= '0;
      mtvec_base  <= RESET_MTVEC[31:2];
`ifdef CSR_VECTORED_EN
      mtvec_mode  <= RESET_MTVEC[0];
`else
      mtvec_mode  <= 1'b0;
`endif
      mscratch    <= '0;
      mepc_r      <= '0;
      mcause_r    <= '0;
      mtval_r     <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      meip_q <= meip;
      plat_q <= plat_irq;
      if (wr_ok) begin
        case (csr_waddr)
          CSR_MSTATUS: begin
            st_mie  <= csr_wdata[MSTATUS_MIE];
            st_mpie <= csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_r    <= csr_wdata & MIE_MASK;
          CSR_MTVEC: begin
            mtvec_base <= csr_wdata[31:2];
`ifdef CSR_VECTORED_EN
            mtvec_mode <= csr_wdata[0];
`endif
          end
          CSR_MSCRATCH: mscratch <= csr_wdata;
          CSR_MEPC:     mepc_r   <= csr_wdata[31:2];
          CSR_MCAUSE:   mcause_r <= csr_wdata;
          CSR_MTVAL:    mtval_r  <= csr_wdata;
          CSR_MIP:      msip     <= csr_wdata[IRQ_MSI];
          default: ;
        endcase
      end
      case (state)
        ST_IDLE: begin
          if (exc_take || int_take) begin
            st_mpie     <= st_mie;
            st_mie      <= 1'b0;
            state       <= ST_REDIR;
            redir_valid <= 1'b1;
            if (exc_take) begin
              mepc_r   <= exc_pc[31:2];
              mcause_r <= exc_cause;
              mtval_r  <= exc_tval;
              redir_pc <= base;
            end else begin
              mepc_r   <= int_pc[31:2];
              mcause_r <= {1'b1, 26'b0, int_code};
              mtval_r  <= '0;
              redir_pc <= int_target;
            end
          end else if (mret_take) begin
            st_mie      <= st_mpie;
            st_mpie     <= 1'b1;
            state       <= ST_REDIR;
            redir_valid <= 1'b1;
            redir_pc    <= {mepc_r, 2'b00};
          end
        end
        ST_REDIR: begin
          if (redir_ready) begin
            state       <= ST_IDLE;
            redir_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - directed and randomized checks of csr_trap_ctrl against a behavioural model
module tb_csr_trap_ctrl;

  localparam int NPI = 4;
  localparam int HID = 7;
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] MTVEC_W    = 32'h0000_0101;
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_W    = 32'h0000_0100;
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [11:0]    csr_raddr = '0, csr_waddr = '0;
  logic [31:0]    csr_rdata, csr_wdata = '0;
  logic           csr_illegal, csr_we = 1'b0;
  logic           exc_valid = 1'b0, mret_valid = 1'b0, int_block = 1'b0, meip = 1'b0;
  logic [31:0]    exc_cause = '0, exc_tval = '0, exc_pc = '0, int_pc = '0;
  logic [NPI-1:0] plat_irq = '0;
  logic           redir_valid, redir_ready = 1'b0;
  logic [31:0]    redir_pc;

  int n_chk = 0;
  int n_fail = 0;

  csr_trap_ctrl #(
    .XLEN(32), .NUM_PLAT_IRQ(NPI), .TIMER_DIV(2), .RESET_MTVEC(32'h0), .HART_ID(HID)
  ) dut (
    .clk(clk), .rst(rst), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
    .int_pc(int_pc), .mret_valid(mret_valid), .int_block(int_block), .meip(meip),
    .plat_irq(plat_irq), .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready)
  );

  always #20 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_raddr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Writable field mask per address, as the register map defines it
  function automatic logic [31:0] wmask(input logic [11:0] a);
    case (a)
      12'h304: return 32'h0000_0888 | (((32'd1 << NPI) - 32'd1) << 16);
      12'h305: return MTVEC_MASK;
      12'h341: return 32'hFFFF_FFFC;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] int_target(input int code);
`ifdef CSR_VECTORED_EN
    return 32'h100 + 32'(4 * code);
`else
    return 32'h100 + 32'(0 * code);
`endif
  endfunction

  initial begin
    logic [31:0] d, t0, t1;
    logic [11:0] addrs [8];
    logic        found;
    int          idx;
    addrs = '{12'h340, 12'h305, 12'h304, 12'h341, 12'h342, 12'h343, 12'h7C0, 12'h7C1};

    // Reset state
    do_reset();
    check("rst_redir_valid", {31'b0, redir_valid}, 32'h0);
    check("rst_redir_pc", redir_pc, 32'h0);
    rd(12'h300, d); check("rst_mstatus", d, 32'h0000_1800);
    rd(12'hF14, d); check("rst_mhartid", d, 32'(HID));
    rd(12'h7C0, d); check("rst_mtimecmp", d, 32'hFFFF_FFFF);
    rd(12'h7C1, d); check("rst_mtimecmph", d, 32'hFFFF_FFFF);
    rd(12'h304, d); check("rst_mie", d, 32'h0);
    tick(); tick();
    check("rst_idle_valid", {31'b0, redir_valid}, 32'h0);

    // Timer interrupt
    do_reset();
    wr(12'h305, MTVEC_W);
    wr(12'h7C0, 32'd10);
    wr(12'h7C1, 32'd0);
    wr(12'h304, 32'h80);
    int_pc = 32'h200;
    wr(12'h300, 32'h8);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      rd(12'h344, d);
      if (d[7]) found = 1'b1;
      else tick();
    end
    check("mtip_seen", {31'b0, found}, 32'h1);
    rd(12'hC01, d); check("mtip_at_mtime", d, 32'd10);
    check("mti_not_yet", {31'b0, redir_valid}, 32'h0);
    tick();
    check("mti_valid", {31'b0, redir_valid}, 32'h1);
    check("mti_pc", redir_pc, int_target(7));
    rd(12'h342, d); check("mti_mcause", d, 32'h8000_0007);
    rd(12'h341, d); check("mti_mepc", d, 32'h200);
    rd(12'h300, d); check("mti_mstatus", d, 32'h0000_1880);
    redir_ready = 1'b1; tick(); redir_ready = 1'b0;
    check("mti_done", {31'b0, redir_valid}, 32'h0);

    // Exception beats a simultaneous external interrupt
    wr(12'h7C1, 32'hFFFF_FFFF);
    wr(12'h304, 32'h800);
    wr(12'h300, 32'h8);
    meip = 1'b1; tick();
    exc_valid = 1'b1; exc_cause = 32'd2; exc_tval = 32'hDEAD; exc_pc = 32'h40;
    tick();
    exc_valid = 1'b0;
    check("exc_valid", {31'b0, redir_valid}, 32'h1);
    check("exc_pc", redir_pc, 32'h100);
    rd(12'h342, d); check("exc_mcause", d, 32'd2);
    rd(12'h341, d); check("exc_mepc", d, 32'h40);
    rd(12'h343, d); check("exc_mtval", d, 32'hDEAD);

    // Stall: pc stable, new exception ignored, CSR write still accepted
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin exc_valid = 1'b1; exc_cause = 32'd5; exc_pc = 32'h80; end
      tick();
      exc_valid = 1'b0;
      check("stall_valid", {31'b0, redir_valid}, 32'h1);
      check("stall_pc", redir_pc, 32'h100);
    end
    rd(12'h342, d); check("stall_mcause", d, 32'd2);
    wr(12'h340, 32'hCAFE);
    rd(12'h340, d); check("stall_csr_wr", d, 32'hCAFE);
    redir_ready = 1'b1; tick(); redir_ready = 1'b0;
    meip = 1'b0;
    check("stall_done", {31'b0, redir_valid}, 32'h0);
    rd(12'h300, d); check("exc_mstatus", d, 32'h0000_1880);

    // Platform IRQ 2 trap then mret; mret beats a same-cycle CSR write
    wr(12'h304, 32'h1 << 18);
    wr(12'h300, 32'h8);
    int_pc = 32'h300; plat_irq = 4'b0100;
    tick(); tick();
    check("plat_valid", {31'b0, redir_valid}, 32'h1);
    check("plat_pc", redir_pc, int_target(18));
    rd(12'h342, d); check("plat_mcause", d, 32'h8000_0012);
    rd(12'h341, d); check("plat_mepc", d, 32'h300);
    plat_irq = '0; redir_ready = 1'b1; tick(); redir_ready = 1'b0;
    mret_valid = 1'b1; csr_we = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'h5555;
    tick();
    mret_valid = 1'b0; csr_we = 1'b0;
    check("mret_valid", {31'b0, redir_valid}, 32'h1);
    check("mret_pc", redir_pc, 32'h300);
    rd(12'h300, d); check("mret_mstatus", d, 32'h0000_1888);
    rd(12'h340, d); check("mret_drop_wr", d, 32'hCAFE);
    redir_ready = 1'b1; tick(); redir_ready = 1'b0;

    // Illegal accesses
    rd(12'h7FF, d); check("ill_rdata", d, 32'h0);
    check("ill_read", {31'b0, csr_illegal}, 32'h1);
    rd(12'h340, d); check("legal_read", {31'b0, csr_illegal}, 32'h0);
    rd(12'hC01, t0);
    csr_we = 1'b1; csr_waddr = 12'hC01; csr_wdata = 32'h0;
    #1; check("ill_write_ro", {31'b0, csr_illegal}, 32'h1);
    tick(); csr_we = 1'b0;
    rd(12'hC01, t1);
    check("mtime_unaffected", {31'b0, (t1 != 0) && ((t1 - t0) <= 32'd1)}, 32'h1);

    // Randomized writes against the field-mask model
    wr(12'h300, 32'h0);
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 7);
      t0 = $urandom;
      wr(addrs[idx], t0);
      rd(addrs[idx], d);
      check($sformatf("rand_%03h", addrs[idx]), d, t0 & wmask(addrs[idx]));
    end
    check("rand_no_redir", {31'b0, redir_valid}, 32'h0);

    // Reset in the middle of a redirect drops it immediately
    exc_valid = 1'b1; exc_cause = 32'd4; exc_pc = 32'h60;
    tick(); exc_valid = 1'b0;
    check("arst_pre", {31'b0, redir_valid}, 32'h1);
    #5 rst = 1'b1;
    #1 check("arst_drop", {31'b0, redir_valid}, 32'h0);
    tick(); rst = 1'b0; tick();
    check("arst_after", {31'b0, redir_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
